packetizer_vc_table_mflit: RTL and testbench
============================================

Name: packetizer_vc_table_mflit

Overview:
- Parametrised successor to the fixed-width 1/2/3/4-flit packetizers with a static VC table.
- Accepts one wide data word plus destination, then serialises it into NUM_FLITS NoC flits with head/tail/VC/destination headers.
- The VC comes from a runtime-programmable destination-to-VC table.
- Sits between a module's streaming output and a NoC router input port; ready/valid on both sides.

Parameters:
- ADDRESS_WIDTH, 4, router address width.
- VC_ADDRESS_WIDTH, 1, VC id width.
- WIDTH_IN, 100, input data width.
- WIDTH_OUT, 36, flit width.
- NUM_FLITS, 4, flits per packet, 1..16.
- NUM_DEST, 4, VC table entries.
- DEST, '{NUM_DEST{1}}, reset destination of each table entry.
- VC, '{NUM_DEST{1}}, reset VC of each table entry.
- DEFAULT_VC, 0, VC used when no table entry matches.

Derived constants and legality:
- PAYLOAD_W = WIDTH_OUT-3-VC_ADDRESS_WIDTH.
- Elaboration error unless WIDTH_IN <= NUM_FLITS*PAYLOAD_W - ADDRESS_WIDTH.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- data_in  in  WIDTH_IN  packet data
- valid_in  in  1  data_in/dst_in valid
- dst_in  in  ADDRESS_WIDTH  destination router
- ready_out  out  1  packetizer can accept
- data_out  out  WIDTH_OUT  flit
- valid_out  out  1  flit valid
- ready_in  in  1  router accepts flit
- cfg_we  in  1  table write strobe
- cfg_idx  in  $clog2(NUM_DEST)  entry index
- cfg_dest  in  ADDRESS_WIDTH  entry destination
- cfg_vc  in  VC_ADDRESS_WIDTH  entry VC

Behaviour:
- Single clock clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - FSM to IDLE, flit counter 0.
  - valid_out=0, data_out=0, ready_out=1.
  - Table loaded from DEST/VC parameters.
  - Capture registers cleared.
- Flit format, MSB first: [WIDTH_OUT-1] valid, [WIDTH_OUT-2] head, [WIDTH_OUT-3] tail, next VC_ADDRESS_WIDTH bits vc, low PAYLOAD_W bits payload.
- Head flit (cnt=0):
  - payload = {dst, data[PAYLOAD_W-ADDRESS_WIDTH-1:0]}.
- Flit k>0:
  - payload = next PAYLOAD_W data bits, LSB-first slicing.
  - Bits beyond WIDTH_IN are zero.
- Head/tail flags:
  - Tail set on flit NUM_FLITS-1.
  - NUM_FLITS=1 gives head=tail=1 on the single flit.
- VC lookup:
  - Combinational compare of dst_in against all entries.
  - Lowest matching index wins; no match gives DEFAULT_VC.
  - Result is latched at capture; the packet keeps its VC even if the table changes mid-packet.
- Table write:
  - cfg_we at a rising edge updates entry cfg_idx.
  - Takes effect for lookups from the next cycle.
  - A capture in the same cycle uses the old value.
  - cfg_idx >= NUM_DEST is ignored.
- FSM IDLE:
  - ready_out=1, valid_out=0.
  - valid_in&&ready_out captures data_in, dst_in and the looked-up vc, sets cnt=0, goes to SEND.
- FSM SEND:
  - valid_out=1; data_out = flit(cnt), driven from registers only.
  - data_out is held stable while ready_in=0.
  - ready_in on cnt<NUM_FLITS-1: cnt++.
  - ready_in on cnt==NUM_FLITS-1 (tail): if valid_in, capture the next packet and stay in SEND with cnt=0; else go to IDLE.
- ready_out = IDLE || (SEND && cnt==NUM_FLITS-1 && ready_in).
  - The combinational ready_in->ready_out path is intentional.
  - Gives sustained throughput of one flit per cycle with no inter-packet bubble.
- Latency: first flit on data_out one cycle after the accepting edge.
- Reset mid-packet: packet is discarded; no tail is emitted; the next packet starts with a head flit.
- data_out is all-zero whenever valid_out=0.

Optional Feature:
- Macro: PACKETIZER_STATS_EN.
- Defined:
  - Adds output pkt_count[31:0], reset 0.
  - Increments by 1 on each accepted tail flit (valid_out&&ready_in&&tail); wraps 0xFFFFFFFF->0.
  - Adds output no_match, a 1-cycle pulse on a capture that used DEFAULT_VC.
- Undefined: neither port exists; no counter logic is present.

Test Plan:
- Reset table, defaults, dst_in=1, data_in=100'h0_1234_5678_9ABC_DEF0_1122_3344, ready_in=1 -> 4 flits on consecutive cycles.
  - Flit 0: head=1, vc=1, payload[31:28]=1, payload[27:0]=data[27:0].
  - Flit 3: tail=1, payload = data[99:92] zero-extended.
- Same packet with ready_in low for 3 cycles at flit 2 -> flit 2 held bit-identical; ready_out=0 throughout; cnt resumes; total 7 cycles.
- Two back-to-back packets, valid_in held high, ready_in=1 -> 8 consecutive valid flits; ready_out high only in the tail cycles; second head immediately follows first tail.
- cfg_we idx=2, dest=5, vc=0 in the same cycle as capturing dst_in=5 -> that packet uses DEFAULT_VC 0 (no match); next dst=5 packet uses vc=0 via entry 2.
- Table rewrite during flit 1 of a dst=1 packet -> remaining flits keep vc=1.
- rst_n low during flit 2 -> valid_out=0 and data_out=0 immediately; after release, ready_out=1 and the next packet starts with head=1.
- NUM_FLITS=1 build -> single flit with head=tail=1 every cycle under continuous valid_in/ready_in.
- PACKETIZER_STATS_EN build -> pkt_count=3 after 3 packets.

Source files
------------

// File: rtl/packetizer_vc_table_mflit.sv
// Serialises one wide word plus destination into NUM_FLITS NoC flits; VC from a runtime dest->VC table.
// Optional PACKETIZER_STATS_EN adds pkt_count and no_match outputs.
module packetizer_vc_table_mflit #(
  parameter int unsigned ADDRESS_WIDTH    = 4,
  parameter int unsigned VC_ADDRESS_WIDTH = 1,
  parameter int unsigned WIDTH_IN         = 100,
  parameter int unsigned WIDTH_OUT        = 36,
  parameter int unsigned NUM_FLITS        = 4,
  parameter int unsigned NUM_DEST         = 4,
  parameter logic [NUM_DEST-1:0][ADDRESS_WIDTH-1:0] DEST =
      {NUM_DEST{ADDRESS_WIDTH'(1)}},
  parameter logic [NUM_DEST-1:0][VC_ADDRESS_WIDTH-1:0] VC =
      {NUM_DEST{VC_ADDRESS_WIDTH'(1)}},
  parameter logic [VC_ADDRESS_WIDTH-1:0] DEFAULT_VC = '0,
  localparam int unsigned IDX_W = (NUM_DEST > 1) ? $clog2(NUM_DEST) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [WIDTH_IN-1:0]         data_in,
  input  logic                        valid_in,
  input  logic [ADDRESS_WIDTH-1:0]    dst_in,
  output logic                        ready_out,
  output logic [WIDTH_OUT-1:0]        data_out,
  output logic                        valid_out,
  input  logic                        ready_in,
  input  logic                        cfg_we,
  input  logic [IDX_W-1:0]            cfg_idx,
  input  logic [ADDRESS_WIDTH-1:0]    cfg_dest,
  input  logic [VC_ADDRESS_WIDTH-1:0] cfg_vc
`ifdef PACKETIZER_STATS_EN
  ,
  output logic [31:0]                 pkt_count,
  output logic                        no_match
`endif
);

  localparam int unsigned PAYLOAD_W   = WIDTH_OUT - 3 - VC_ADDRESS_WIDTH;
  localparam int unsigned FULL_W      = NUM_FLITS * PAYLOAD_W;
  localparam int unsigned HEAD_DATA_W = PAYLOAD_W - ADDRESS_WIDTH;
  localparam int unsigned CNT_W       = (NUM_FLITS > 1) ? $clog2(NUM_FLITS) : 1;
  localparam logic [CNT_W-1:0]  LAST     = CNT_W'(NUM_FLITS - 1);
  localparam logic [FULL_W-1:0] LOW_MASK = (FULL_W'(1) << HEAD_DATA_W) - FULL_W'(1);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_SEND = 1'b1;

  if (WIDTH_IN > FULL_W - ADDRESS_WIDTH) begin : g_width_check
    $error("WIDTH_IN does not fit in NUM_FLITS flits");
  end
  if (NUM_FLITS < 1 || NUM_FLITS > 16) begin : g_flits_check
    $error("NUM_FLITS must be 1..16");
  end

  logic                        state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [WIDTH_IN-1:0]         data_q;
  logic [ADDRESS_WIDTH-1:0]    dst_q;
  logic [VC_ADDRESS_WIDTH-1:0] vc_q;
  logic [NUM_DEST-1:0][ADDRESS_WIDTH-1:0]    tbl_dest_q;
  logic [NUM_DEST-1:0][VC_ADDRESS_WIDTH-1:0] tbl_vc_q;

  logic                        is_last;
  logic                        capture;
  logic [NUM_DEST-1:0]         match;
  logic [VC_ADDRESS_WIDTH-1:0] lookup_vc;
  logic [FULL_W-1:0]           full;
  logic [PAYLOAD_W-1:0]        payload;

  // Descending scan so the lowest matching index is applied last and wins.
  always_comb begin
    lookup_vc = DEFAULT_VC;
    for (int i = 0; i < NUM_DEST; i++) begin
      match[i] = (tbl_dest_q[i] == dst_in);
    end
    for (int i = NUM_DEST - 1; i >= 0; i--) begin
      if (match[i]) lookup_vc = tbl_vc_q[i];
    end
  end

  assign is_last   = (cnt_q == LAST);
  assign ready_out = (state_q == ST_IDLE) || (is_last && ready_in);
  assign capture   = valid_in && ready_out;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_SEND && ready_in) begin
      if (is_last) state_d = ST_IDLE;
      else         cnt_d   = cnt_q + CNT_W'(1);
    end
    if (capture) begin
      state_d = ST_SEND;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      data_q     <= '0;
      dst_q      <= '0;
      vc_q       <= '0;
      tbl_dest_q <= DEST;
      tbl_vc_q   <= VC;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        data_q <= data_in;
        dst_q  <= dst_in;
        vc_q   <= lookup_vc;
      end
      if (cfg_we && (32'(cfg_idx) < NUM_DEST)) begin
        tbl_dest_q[cfg_idx] <= cfg_dest;
        tbl_vc_q[cfg_idx]   <= cfg_vc;
      end
    end
  end

  // Packet bit stream: destination spliced in above the head flit's data bits.
  assign full = ((FULL_W'(data_q) & ~LOW_MASK) << ADDRESS_WIDTH)
              | (FULL_W'(data_q) & LOW_MASK)
              | (FULL_W'(dst_q) << HEAD_DATA_W);
  assign payload = PAYLOAD_W'(full >> (32'(cnt_q) * PAYLOAD_W));

  assign valid_out = (state_q == ST_SEND);
  assign data_out  = valid_out ? {1'b1, (cnt_q == '0), is_last, vc_q, payload} : '0;

`ifdef PACKETIZER_STATS_EN
  logic [31:0] pkt_count_q;
  logic        no_match_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_count_q <= '0;
      no_match_q  <= 1'b0;
    end else begin
      if (valid_out && ready_in && is_last) pkt_count_q <= pkt_count_q + 32'd1;
      no_match_q <= capture && !(|match);
    end
  end

  assign pkt_count = pkt_count_q;
  assign no_match  = no_match_q;
`endif

endmodule

// File: tb/tb_packetizer_vc_table_mflit.sv
// Directed bench for packetizer_vc_table_mflit; one 4-flit and one 1-flit instance.
// Define PACKETIZER_STATS_EN to also exercise pkt_count/no_match.
module tb_packetizer_vc_table_mflit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [99:0] data_in;
  logic        valid_in;
  logic [3:0]  dst_in;
  logic        ready_out;
  logic [35:0] data_out;
  logic        valid_out;
  logic        ready_in;
  logic        cfg_we;
  logic [1:0]  cfg_idx;
  logic [3:0]  cfg_dest;
  logic        cfg_vc;

  logic [15:0] o_data_in;
  logic        o_valid_in;
  logic [3:0]  o_dst_in;
  logic        o_ready_out;
  logic [35:0] o_data_out;
  logic        o_valid_out;
  logic        o_ready_in;

`ifdef PACKETIZER_STATS_EN
  logic [31:0] pkt_count, o_pkt_count;
  logic        no_match, o_no_match;
`endif

  int checks = 0;
  int passed = 0;

  localparam logic [99:0] D  = 100'h0_1234_5678_9ABC_DEF0_1122_3344;
  localparam logic [99:0] D2 = {8'hC5, 32'h3333_3333, 32'h2222_2222, 28'h111_1111};

  logic [35:0] exp_a [4] = '{36'hD_1122_3344, 36'h9_ABCD_EF01, 36'h9_2345_6789, 36'hB_0000_0001};
  logic [35:0] exp_b [4] = '{36'hD_1111_1111, 36'h9_2222_2222, 36'h9_3333_3333, 36'hB_0000_00C5};
  logic [35:0] exp_c [4] = '{36'hC_5111_1111, 36'h8_2222_2222, 36'h8_3333_3333, 36'hA_0000_00C5};

  always #5 clk = ~clk;

  packetizer_vc_table_mflit u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .data_in  (data_in),
    .valid_in (valid_in),
    .dst_in   (dst_in),
    .ready_out(ready_out),
    .data_out (data_out),
    .valid_out(valid_out),
    .ready_in (ready_in),
    .cfg_we   (cfg_we),
    .cfg_idx  (cfg_idx),
    .cfg_dest (cfg_dest),
    .cfg_vc   (cfg_vc)
`ifdef PACKETIZER_STATS_EN
    ,
    .pkt_count(pkt_count),
    .no_match (no_match)
`endif
  );

  packetizer_vc_table_mflit #(
    .WIDTH_IN (16),
    .NUM_FLITS(1)
  ) u_one (
    .clk      (clk),
    .rst_n    (rst_n),
    .data_in  (o_data_in),
    .valid_in (o_valid_in),
    .dst_in   (o_dst_in),
    .ready_out(o_ready_out),
    .data_out (o_data_out),
    .valid_out(o_valid_out),
    .ready_in (o_ready_in),
    .cfg_we   (1'b0),
    .cfg_idx  (2'd0),
    .cfg_dest (4'd0),
    .cfg_vc   (1'b0)
`ifdef PACKETIZER_STATS_EN
    ,
    .pkt_count(o_pkt_count),
    .no_match (o_no_match)
`endif
  );

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Presents one packet for a single cycle; returns at the negedge showing flit 0.
  task automatic send_start(input logic [3:0] d, input logic [99:0] v);
    @(negedge clk);
    valid_in = 1'b1;
    dst_in   = d;
    data_in  = v;
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (ready_out !== 1'b1) $display("FAIL reset_ready_out: got %b want 1", ready_out);
    else passed++;
    checks++;
    if (valid_out !== 1'b0) $display("FAIL reset_valid_out: got %b want 0", valid_out);
    else passed++;
    checks++;
    if (data_out !== 36'h0) $display("FAIL reset_data_out: got %h want 0", data_out);
    else passed++;
    checks++;
    if (o_valid_out !== 1'b0 || o_ready_out !== 1'b1)
      $display("FAIL reset_one_flit: got v=%b r=%b want v=0 r=1", o_valid_out, o_ready_out);
    else passed++;
  endtask

  task automatic test_basic();
    ready_in = 1'b1;
    send_start(4'd1, D);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (valid_out !== 1'b1 || data_out !== exp_a[k])
        $display("FAIL basic_flit%0d: got v=%b %h want v=1 %h", k, valid_out, data_out, exp_a[k]);
      else passed++;
      checks++;
      if (ready_out !== (k == 3))
        $display("FAIL basic_ready%0d: got %b want %b", k, ready_out, (k == 3));
      else passed++;
      @(negedge clk);
    end
    checks++;
    if (valid_out !== 1'b0 || data_out !== 36'h0 || ready_out !== 1'b1)
      $display("FAIL basic_idle: got v=%b d=%h r=%b want 0 0 1", valid_out, data_out, ready_out);
    else passed++;
  endtask

  task automatic test_stall();
    int map [7] = '{0, 1, 2, 2, 2, 2, 3};
    send_start(4'd1, D);
    for (int c = 0; c < 7; c++) begin
      if (c == 2) ready_in = 1'b0;
      if (c == 5) ready_in = 1'b1;
      checks++;
      if (valid_out !== 1'b1 || data_out !== exp_a[map[c]])
        $display("FAIL stall_c%0d: got v=%b %h want v=1 %h", c, valid_out, data_out,
                 exp_a[map[c]]);
      else passed++;
      if (c < 6) begin
        checks++;
        if (ready_out !== 1'b0) $display("FAIL stall_ready_c%0d: got %b want 0", c, ready_out);
        else passed++;
      end
      @(negedge clk);
    end
    checks++;
    if (valid_out !== 1'b0) $display("FAIL stall_end: got valid %b want 0", valid_out);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [35:0] e;
    @(negedge clk);
    valid_in = 1'b1;
    dst_in   = 4'd1;
    data_in  = D;
    @(negedge clk);
    data_in  = D2;
    for (int c = 0; c < 8; c++) begin
      e = (c < 4) ? exp_a[c] : exp_b[c-4];
      checks++;
      if (valid_out !== 1'b1 || data_out !== e)
        $display("FAIL b2b_c%0d: got v=%b %h want v=1 %h", c, valid_out, data_out, e);
      else passed++;
      checks++;
      if (ready_out !== (c == 3 || c == 7))
        $display("FAIL b2b_ready_c%0d: got %b want %b", c, ready_out, (c == 3 || c == 7));
      else passed++;
      if (c == 4) valid_in = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (valid_out !== 1'b0) $display("FAIL b2b_end: got valid %b want 0", valid_out);
    else passed++;
  endtask

  task automatic cfg_write(input logic [1:0] idx, input logic [3:0] dest, input logic vc);
    @(negedge clk);
    cfg_we = 1'b1; cfg_idx = idx; cfg_dest = dest; cfg_vc = vc;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic test_cfg();
    // Table write coinciding with capture: capture sees the old (no-match) table.
    @(negedge clk);
    cfg_we = 1'b1; cfg_idx = 2'd2; cfg_dest = 4'd5; cfg_vc = 1'b0;
    valid_in = 1'b1; dst_in = 4'd5; data_in = D2;
    @(negedge clk);
    cfg_we = 1'b0; valid_in = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (data_out !== exp_c[k])
        $display("FAIL cfg_same_cycle_flit%0d: got %h want %h", k, data_out, exp_c[k]);
      else passed++;
      @(negedge clk);
    end
    send_start(4'd5, D2);
    checks++;
    if (data_out !== exp_c[0]) $display("FAIL cfg_entry2: got %h want %h", data_out, exp_c[0]);
    else passed++;
    repeat (4) @(negedge clk);
    // Same-cycle write of dst 6 -> vc 1: first packet still default vc 0.
    @(negedge clk);
    cfg_we = 1'b1; cfg_idx = 2'd3; cfg_dest = 4'd6; cfg_vc = 1'b1;
    valid_in = 1'b1; dst_in = 4'd6; data_in = D2;
    @(negedge clk);
    cfg_we = 1'b0; valid_in = 1'b0;
    checks++;
    if (data_out !== 36'hC_6111_1111)
      $display("FAIL cfg_old_value: got %h want %h", data_out, 36'hC_6111_1111);
    else passed++;
    repeat (4) @(negedge clk);
    send_start(4'd6, D2);
    checks++;
    if (data_out !== 36'hD_6111_1111)
      $display("FAIL cfg_new_value: got %h want %h", data_out, 36'hD_6111_1111);
    else passed++;
    repeat (4) @(negedge clk);
    // Entries 1 and 3 both match dst 6; entry 1 (vc 0) must win.
    cfg_write(2'd1, 4'd6, 1'b0);
    send_start(4'd6, D2);
    checks++;
    if (data_out !== 36'hC_6111_1111)
      $display("FAIL cfg_lowest_idx: got %h want %h", data_out, 36'hC_6111_1111);
    else passed++;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_rewrite_mid_packet();
    send_start(4'd1, D);
    @(negedge clk);
    cfg_we = 1'b1; cfg_idx = 2'd0; cfg_dest = 4'd1; cfg_vc = 1'b0;
    for (int k = 1; k < 4; k++) begin
      checks++;
      if (data_out !== exp_a[k])
        $display("FAIL rewrite_flit%0d: got %h want %h", k, data_out, exp_a[k]);
      else passed++;
      @(negedge clk);
      cfg_we = 1'b0;
    end
    send_start(4'd1, D);
    checks++;
    if (data_out !== 36'hC_1122_3344)
      $display("FAIL rewrite_next_pkt: got %h want %h", data_out, 36'hC_1122_3344);
    else passed++;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid_packet();
    send_start(4'd1, D);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (valid_out !== 1'b0 || data_out !== 36'h0)
      $display("FAIL rst_mid_outputs: got v=%b d=%h want 0 0", valid_out, data_out);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (ready_out !== 1'b1) $display("FAIL rst_mid_ready: got %b want 1", ready_out);
    else passed++;
    send_start(4'd1, D);
    checks++;
    if (data_out !== exp_a[0])
      $display("FAIL rst_mid_head: got %h want %h", data_out, exp_a[0]);
    else passed++;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_one_flit();
    logic [15:0] v;
    o_ready_in = 1'b1;
    @(negedge clk);
    o_valid_in = 1'b1;
    o_dst_in   = 4'd1;
    o_data_in  = 16'h1000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      v = 16'h1000 + 16'(i);
      checks++;
      if (o_valid_out !== 1'b1 || o_data_out !== {4'hF, 4'h1, 12'h000, v})
        $display("FAIL one_flit%0d: got v=%b %h want v=1 %h", i, o_valid_out, o_data_out,
                 {4'hF, 4'h1, 12'h000, v});
      else passed++;
      checks++;
      if (o_ready_out !== 1'b1) $display("FAIL one_ready%0d: got %b want 1", i, o_ready_out);
      else passed++;
      o_data_in = v + 16'd1;
    end
    o_valid_in = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (o_valid_out !== 1'b0) $display("FAIL one_end: got valid %b want 0", o_valid_out);
    else passed++;
  endtask

`ifdef PACKETIZER_STATS_EN
  task automatic test_stats();
    do_reset();
    checks++;
    if (pkt_count !== 32'd0) $display("FAIL stats_reset: got %0d want 0", pkt_count);
    else passed++;
    send_start(4'd9, D2);
    checks++;
    if (no_match !== 1'b1) $display("FAIL stats_no_match: got %b want 1", no_match);
    else passed++;
    repeat (4) @(negedge clk);
    send_start(4'd1, D);
    checks++;
    if (no_match !== 1'b0) $display("FAIL stats_match: got %b want 0", no_match);
    else passed++;
    repeat (4) @(negedge clk);
    send_start(4'd1, D2);
    repeat (4) @(negedge clk);
    checks++;
    if (pkt_count !== 32'd3) $display("FAIL stats_count: got %0d want 3", pkt_count);
    else passed++;
  endtask
`endif

  initial begin
    rst_n      = 1'b0;
    data_in    = '0;
    valid_in   = 1'b0;
    dst_in     = '0;
    ready_in   = 1'b1;
    cfg_we     = 1'b0;
    cfg_idx    = '0;
    cfg_dest   = '0;
    cfg_vc     = 1'b0;
    o_data_in  = '0;
    o_valid_in = 1'b0;
    o_dst_in   = '0;
    o_ready_in = 1'b1;

    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_cfg();
    test_rewrite_mid_packet();
    test_reset_mid_packet();
    test_one_flit();
`ifdef PACKETIZER_STATS_EN
    test_stats();
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
